// File: rtl/pcpu_pkg.sv
// ---------------------------------------------------------------------------
// pcpu_pkg : shared types for the pcpu pipeline control logic.
//
// Contents
//   hzd_state_t  - state of the hazard sequencer (RUN / MEM_WAIT / HALT)
//   MEM2REG_LOAD - MemtoReg encoding that marks a load in ID/EX
//   pipe_ctrl_t  - bundle of the seven pipeline enable/flush controls
//   CTRL_*       - the fixed control patterns the sequencer selects between
// ---------------------------------------------------------------------------
package pcpu;

  typedef enum logic [1:0] {
    HZD_RUN      = 2'd0,
    HZD_MEM_WAIT = 2'd1,
    HZD_HALT     = 2'd2
  } hzd_state_t;

  localparam logic [1:0] MEM2REG_LOAD = 2'b01;

  typedef struct packed {
    logic pc_en;
    logic en_ifid;
    logic flush_ifid;
    logic en_idex;
    logic flush_idex;
    logic en_exmem;
    logic en_memwb;
  } pipe_ctrl_t;

  // Everything advances, nothing squashed.
  localparam pipe_ctrl_t CTRL_NORMAL = '{pc_en: 1'b1, en_ifid: 1'b1, flush_ifid: 1'b0,
                                         en_idex: 1'b1, flush_idex: 1'b0,
                                         en_exmem: 1'b1, en_memwb: 1'b1};

  // Whole pipeline frozen (memory wait or halt).
  localparam pipe_ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, en_ifid: 1'b0, flush_ifid: 1'b0,
                                         en_idex: 1'b0, flush_idex: 1'b0,
                                         en_exmem: 1'b0, en_memwb: 1'b0};

  // Taken branch: PC takes the target, the two younger instructions are squashed.
  localparam pipe_ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, en_ifid: 1'b1, flush_ifid: 1'b1,
                                         en_idex: 1'b1, flush_idex: 1'b1,
                                         en_exmem: 1'b1, en_memwb: 1'b1};

  // RAW stall: PC and IF/ID hold, a bubble enters ID/EX, older stages drain.
  localparam pipe_ctrl_t CTRL_RAW    = '{pc_en: 1'b0, en_ifid: 1'b0, flush_ifid: 1'b0,
                                         en_idex: 1'b1, flush_idex: 1'b1,
                                         en_exmem: 1'b1, en_memwb: 1'b1};

  // Forced while reset is asserted: nothing advances, IF/ID and ID/EX hold NOPs.
  localparam pipe_ctrl_t CTRL_RESET  = '{pc_en: 1'b0, en_ifid: 1'b0, flush_ifid: 1'b1,
                                         en_idex: 1'b0, flush_idex: 1'b1,
                                         en_exmem: 1'b0, en_memwb: 1'b0};

endpackage

// File: rtl/pipe_hazard_detect.sv
// ---------------------------------------------------------------------------
// pipe_hazard_detect : purely combinational RAW / load-use detection between
// the instruction in ID and the producers held in ID/EX and EX/MEM.
//
// Parameters
//   FORWARDING : 1 - forwarding exists, only a load in EX causes a stall
//                0 - no forwarding, any RAW against EX or MEM stalls
// Ports
//   Rs1_addr_ID, Rs2_addr_ID : source registers of the ID instruction
//   use_rs1_ID, use_rs2_ID   : the ID instruction actually reads rs1 / rs2
//   Rd_addr_EX, RegWrite_EX, MemtoReg_EX : producer held in ID/EX
//   Rd_addr_MEM, RegWrite_MEM            : producer held in EX/MEM
//   raw    : stall request for the ID instruction
//   ld_use : load-use hazard against EX (independent of FORWARDING)
// ---------------------------------------------------------------------------
module pipe_hazard_detect
  import pcpu::*;
#(
  parameter int FORWARDING = 1
) (
  input  logic [4:0] Rs1_addr_ID,
  input  logic [4:0] Rs2_addr_ID,
  input  logic       use_rs1_ID,
  input  logic       use_rs2_ID,
  input  logic [4:0] Rd_addr_EX,
  input  logic       RegWrite_EX,
  input  logic [1:0] MemtoReg_EX,
  input  logic [4:0] Rd_addr_MEM,
  input  logic       RegWrite_MEM,
  output logic       raw,
  output logic       ld_use
);

  logic hit_ex;
  logic hit_mem;
  logic ex_is_load;
  logic raw_any;

  always_comb begin
    // x0 is hard-wired to zero, so a write to it never creates a dependency.
    hit_ex  = (Rd_addr_EX != 5'd0) &&
              ((use_rs1_ID && (Rs1_addr_ID == Rd_addr_EX)) ||
               (use_rs2_ID && (Rs2_addr_ID == Rd_addr_EX)));
    hit_mem = (Rd_addr_MEM != 5'd0) &&
              ((use_rs1_ID && (Rs1_addr_ID == Rd_addr_MEM)) ||
               (use_rs2_ID && (Rs2_addr_ID == Rd_addr_MEM)));

    ex_is_load = RegWrite_EX && (MemtoReg_EX == MEM2REG_LOAD);
    ld_use     = ex_is_load && hit_ex;
    raw_any    = (RegWrite_EX && hit_ex) || (RegWrite_MEM && hit_mem);

    raw = (FORWARDING != 0) ? ld_use : raw_any;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl : central stall/flush sequencer of the 5-stage pcpu.
//
// Arbitrates load-use/RAW hazards, taken branches in EX and a multi-cycle
// data-memory handshake into the PC / pipeline-register enables and flushes.
// A small FSM tracks memory-wait length and halts on timeout; saturating
// counters record stalled cycles and taken-branch flushes for debug.
//
// Parameters
//   FORWARDING  : 1 - stall only on load-use, 0 - stall on any RAW (EX/MEM)
//   MEM_TIMEOUT : MEM_WAIT cycles tolerated before HALT (0 = never halt)
//   CNT_W       : width of stall_cnt / flush_cnt
// Ports
//   clk_HZD, rstn_HZD            : clock, synchronous active-low reset
//   Rs*_addr_ID, use_rs*_ID      : operands of the ID instruction
//   Rd_addr_EX, RegWrite_EX, MemtoReg_EX : ID/EX producer
//   Rd_addr_MEM, RegWrite_MEM    : EX/MEM producer
//   taken_EX                     : branch/jump resolved taken in EX
//   dmem_req_MEM, dmem_ack_MEM   : data-memory handshake of the MEM stage
//   PC_en, en_*, flush_*         : pipeline controls (combinational)
//   halted, mem_err              : HALT state, sticky timeout flag
//   stall_cnt, flush_cnt         : saturating debug counters
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pcpu::*;
#(
  parameter int FORWARDING  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk_HZD,
  input  logic             rstn_HZD,
  input  logic [4:0]       Rs1_addr_ID,
  input  logic [4:0]       Rs2_addr_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       Rd_addr_EX,
  input  logic             RegWrite_EX,
  input  logic [1:0]       MemtoReg_EX,
  input  logic [4:0]       Rd_addr_MEM,
  input  logic             RegWrite_MEM,
  input  logic             taken_EX,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ack_MEM,
  output logic             PC_en,
  output logic             en_IFID,
  output logic             flush_IFID,
  output logic             en_IDEX,
  output logic             flush_IDEX,
  output logic             en_EXMEM,
  output logic             en_MEMWB,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Wide enough to hold MEM_TIMEOUT itself without wrapping.
  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + WAIT_W'(1);
  endfunction

  // Hazard detection
  logic raw;
  logic ld_use;

  pipe_hazard_detect #(
    .FORWARDING (FORWARDING)
  ) u_detect (
    .Rs1_addr_ID  (Rs1_addr_ID),
    .Rs2_addr_ID  (Rs2_addr_ID),
    .use_rs1_ID   (use_rs1_ID),
    .use_rs2_ID   (use_rs2_ID),
    .Rd_addr_EX   (Rd_addr_EX),
    .RegWrite_EX  (RegWrite_EX),
    .MemtoReg_EX  (MemtoReg_EX),
    .Rd_addr_MEM  (Rd_addr_MEM),
    .RegWrite_MEM (RegWrite_MEM),
    .raw          (raw),
    .ld_use       (ld_use)
  );

  // ld_use is already folded into raw; it is kept for visibility only.
  logic ld_use_unused;
  assign ld_use_unused = ld_use;

  hzd_state_t        state_q,     state_d;
  logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic              mem_err_q,   mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic       mem_stall;
  logic       take_branch;
  logic       count_flush;
  pipe_ctrl_t ctrl_run;
  pipe_ctrl_t ctrl_core;
  pipe_ctrl_t ctrl_out;

  always_comb begin
    mem_stall = dmem_req_MEM && !dmem_ack_MEM;

    // Decision used whenever the pipeline is free to move (RUN without a
    // memory stall, or the release cycle of MEM_WAIT). A branch squashes the
    // ID instruction, so a coincident RAW stall is moot.
    ctrl_run    = CTRL_NORMAL;
    take_branch = 1'b0;
    if (taken_EX) begin
      ctrl_run    = CTRL_BRANCH;
      take_branch = 1'b1;
    end else if (raw) begin
      ctrl_run = CTRL_RAW;
    end

    ctrl_core   = ctrl_run;
    count_flush = take_branch;
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;

    case (state_q)
      HZD_HALT: begin
        ctrl_core   = CTRL_FREEZE;
        count_flush = 1'b0;
      end
      HZD_MEM_WAIT: begin
        if (!dmem_ack_MEM) begin
          // Still waiting: freeze and leave branch/RAW pending on the inputs.
          ctrl_core   = CTRL_FREEZE;
          count_flush = 1'b0;
          if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_LIMIT)) begin
            state_d   = HZD_HALT;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_inc(wait_cnt_q);
          end
        end else begin
          // Release cycle: ctrl_run applies any pending branch or RAW stall.
          state_d    = HZD_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        if (mem_stall) begin
          ctrl_core   = CTRL_FREEZE;
          count_flush = 1'b0;
          state_d     = HZD_MEM_WAIT;
          wait_cnt_d  = WAIT_W'(1);
        end
      end
    endcase

    stall_cnt_d = ctrl_core.pc_en ? stall_cnt_q : sat_inc(stall_cnt_q);
    flush_cnt_d = count_flush ? sat_inc(flush_cnt_q) : flush_cnt_q;

    ctrl_out = rstn_HZD ? ctrl_core : CTRL_RESET;
  end

  always_ff @(posedge clk_HZD) begin
    if (!rstn_HZD) begin
      state_q     <= HZD_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PC_en      = ctrl_out.pc_en;
  assign en_IFID    = ctrl_out.en_ifid;
  assign flush_IFID = ctrl_out.flush_ifid;
  assign en_IDEX    = ctrl_out.en_idex;
  assign flush_IDEX = ctrl_out.flush_idex;
  assign en_EXMEM   = ctrl_out.en_exmem;
  assign en_MEMWB   = ctrl_out.en_memwb;

  assign halted    = rstn_HZD && (state_q == HZD_HALT);
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for pipeline_hazard_ctrl. Two instances share all inputs:
//   index 0 : FORWARDING=1, MEM_TIMEOUT=4, CNT_W=32
//   index 1 : FORWARDING=0, MEM_TIMEOUT=4, CNT_W=3 (counter saturation)
// A cycle-level behavioural model predicts every output; directed literal
// expectations pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [4:0] rs1, rs2, rd_ex, rd_mem;
  logic       u1, u2, rw_ex, rw_mem, taken, req, ack;
  logic [1:0] m2r;

  wire [1:0]  pc_en, en_ifid, fl_ifid, en_idex, fl_idex, en_exmem, en_memwb;
  wire [1:0]  halted, mem_err;
  wire [31:0] stall1, flush1;
  wire [2:0]  stall0, flush0;

  pipeline_hazard_ctrl #(.FORWARDING(1), .MEM_TIMEOUT(TO), .CNT_W(32)) u_fwd1 (
    .clk_HZD(clk), .rstn_HZD(rstn),
    .Rs1_addr_ID(rs1), .Rs2_addr_ID(rs2), .use_rs1_ID(u1), .use_rs2_ID(u2),
    .Rd_addr_EX(rd_ex), .RegWrite_EX(rw_ex), .MemtoReg_EX(m2r),
    .Rd_addr_MEM(rd_mem), .RegWrite_MEM(rw_mem), .taken_EX(taken),
    .dmem_req_MEM(req), .dmem_ack_MEM(ack),
    .PC_en(pc_en[0]), .en_IFID(en_ifid[0]), .flush_IFID(fl_ifid[0]),
    .en_IDEX(en_idex[0]), .flush_IDEX(fl_idex[0]), .en_EXMEM(en_exmem[0]),
    .en_MEMWB(en_memwb[0]), .halted(halted[0]), .mem_err(mem_err[0]),
    .stall_cnt(stall1), .flush_cnt(flush1)
  );

  pipeline_hazard_ctrl #(.FORWARDING(0), .MEM_TIMEOUT(TO), .CNT_W(3)) u_fwd0 (
    .clk_HZD(clk), .rstn_HZD(rstn),
    .Rs1_addr_ID(rs1), .Rs2_addr_ID(rs2), .use_rs1_ID(u1), .use_rs2_ID(u2),
    .Rd_addr_EX(rd_ex), .RegWrite_EX(rw_ex), .MemtoReg_EX(m2r),
    .Rd_addr_MEM(rd_mem), .RegWrite_MEM(rw_mem), .taken_EX(taken),
    .dmem_req_MEM(req), .dmem_ack_MEM(ack),
    .PC_en(pc_en[1]), .en_IFID(en_ifid[1]), .flush_IFID(fl_ifid[1]),
    .en_IDEX(en_idex[1]), .flush_IDEX(fl_idex[1]), .en_EXMEM(en_exmem[1]),
    .en_MEMWB(en_memwb[1]), .halted(halted[1]), .mem_err(mem_err[1]),
    .stall_cnt(stall0), .flush_cnt(flush0)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Model state: whether halted, whether waiting and for how many cycles,
  // sticky error, and the two counters as plain integers.
  bit     m_halt  [2];
  bit     m_wait  [2];
  bit     m_err   [2];
  int     m_wn    [2];
  longint m_stall [2];
  longint m_flush [2];
  longint cmax    [2] = '{64'hFFFF_FFFF, 64'd7};
  int     fwdp    [2] = '{1, 0};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic bit must_stall(int fwd);
    bit hit_ex, hit_mem, is_load;
    hit_ex  = (rd_ex != 0) && ((u1 && rs1 == rd_ex) || (u2 && rs2 == rd_ex));
    hit_mem = (rd_mem != 0) && ((u1 && rs1 == rd_mem) || (u2 && rs2 == rd_mem));
    is_load = rw_ex && (m2r == 2'b01);
    if (fwd != 0) return is_load && hit_ex;
    return (rw_ex && hit_ex) || (rw_mem && hit_mem);
  endfunction

  // Bit order: {PC_en, en_IFID, flush_IFID, en_IDEX, flush_IDEX, en_EXMEM, en_MEMWB}
  function automatic bit [6:0] exp_ctrl(int k);
    if (!rstn)                              return 7'b0010100;
    if (m_halt[k])                          return 7'b0000000;
    if (m_wait[k] ? !ack : (req && !ack))   return 7'b0000000;
    if (taken)                              return 7'b1111111;
    if (must_stall(fwdp[k]))                return 7'b0001111;
    return 7'b1101011;
  endfunction

  function automatic bit [6:0] act_ctrl(int k);
    return {pc_en[k], en_ifid[k], fl_ifid[k], en_idex[k], fl_idex[k], en_exmem[k], en_memwb[k]};
  endfunction

  // Model update on the active edge, from pre-edge inputs and state.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit [6:0] e;
      e = exp_ctrl(k);
      if (!rstn) begin
        m_halt[k] = 0; m_wait[k] = 0; m_err[k] = 0; m_wn[k] = 0;
        m_stall[k] = 0; m_flush[k] = 0;
      end else begin
        if (!e[6] && m_stall[k] < cmax[k]) m_stall[k]++;
        if (e == 7'b1111111 && m_flush[k] < cmax[k]) m_flush[k]++;
        if (m_halt[k]) begin
        end else if (m_wait[k]) begin
          if (ack) m_wait[k] = 0;
          else if (TO != 0 && m_wn[k] == TO) begin
            m_halt[k] = 1; m_wait[k] = 0; m_err[k] = 1;
          end else m_wn[k]++;
        end else if (req && !ack) begin
          m_wait[k] = 1; m_wn[k] = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("ctrl[%0d]", k), 64'(act_ctrl(k)), 64'(exp_ctrl(k)));
        check($sformatf("halted[%0d]", k), 64'(halted[k]), 64'(rstn && m_halt[k]));
        check($sformatf("mem_err[%0d]", k), 64'(mem_err[k]), 64'(m_err[k]));
        check($sformatf("stall_cnt[%0d]", k), (k == 0) ? 64'(stall1) : 64'(stall0), 64'(m_stall[k]));
        check($sformatf("flush_cnt[%0d]", k), (k == 0) ? 64'(flush1) : 64'(flush0), 64'(m_flush[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rs1 = 0; rs2 = 0; rd_ex = 0; rd_mem = 0; u1 = 0; u2 = 0;
    rw_ex = 0; rw_mem = 0; m2r = 0; taken = 0; req = 0; ack = 0;
  endtask

  task automatic set_ld_use();
    rw_ex = 1; m2r = 2'b01; rd_ex = 5; rs1 = 5; u1 = 1;
  endtask

  task automatic do_reset();
    tick(); rstn = 0; idle_in();
    tick(); rstn = 1;
  endtask

  initial begin
    idle_in();
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_flush_ifid", 64'(fl_ifid[0]), 64'd1);
    check("rst_pc_en", 64'(pc_en[0]), 64'd0);
    tick(); rstn = 1;
    @(negedge clk);
    check("rst_stall_cnt", 64'(stall1), 64'd0);
    check("rst_flush_cnt", 64'(flush1), 64'd0);
    check("rst_mem_err", 64'(mem_err[0]), 64'd0);
    check("rst_halted", 64'(halted[0]), 64'd0);
    check("rst_pc_en_run", 64'(pc_en[0]), 64'd1);

    // Load-use: one stall cycle
    tick(); set_ld_use();
    @(negedge clk);
    check("lu_pc_en", 64'(pc_en[0]), 64'd0);
    check("lu_en_ifid", 64'(en_ifid[0]), 64'd0);
    check("lu_flush_idex", 64'(fl_idex[0]), 64'd1);
    check("lu_en_idex", 64'(en_idex[0]), 64'd1);
    tick(); idle_in();
    @(negedge clk);
    check("lu_stall_cnt", 64'(stall1), 64'd1);
    check("lu_released", 64'(pc_en[0]), 64'd1);

    // x0 destination and unused operand never stall
    tick(); rw_ex = 1; m2r = 2'b01; rd_ex = 0; rs1 = 0; u1 = 1;
    @(negedge clk);
    check("x0_pc_en_f1", 64'(pc_en[0]), 64'd1);
    check("x0_pc_en_f0", 64'(pc_en[1]), 64'd1);
    tick(); rd_ex = 5; rs2 = 5; u2 = 0; u1 = 0;
    @(negedge clk);
    check("unused_pc_en_f1", 64'(pc_en[0]), 64'd1);
    check("unused_pc_en_f0", 64'(pc_en[1]), 64'd1);
    tick(); idle_in();
    @(negedge clk);
    check("x0_stall_cnt", 64'(stall1), 64'd1);

    // Branch coincident with load-use: flush wins
    do_reset(); set_ld_use(); taken = 1;
    @(negedge clk);
    check("br_flush_ifid", 64'(fl_ifid[0]), 64'd1);
    check("br_flush_idex", 64'(fl_idex[0]), 64'd1);
    check("br_pc_en", 64'(pc_en[0]), 64'd1);
    tick(); idle_in();
    @(negedge clk);
    check("br_flush_cnt", 64'(flush1), 64'd1);
    check("br_stall_cnt", 64'(stall1), 64'd0);

    // Memory wait: three frozen cycles, then release
    do_reset(); req = 1; ack = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mw_pc_en_%0d", i), 64'(pc_en[0]), 64'd0);
      check($sformatf("mw_en_memwb_%0d", i), 64'(en_memwb[0]), 64'd0);
      tick();
    end
    ack = 1;
    @(negedge clk);
    check("mw_release", 64'(act_ctrl(0)), 64'(7'b1101011));
    tick(); idle_in();
    @(negedge clk);
    check("mw_stall_cnt", 64'(stall1), 64'd3);
    check("mw_halted", 64'(halted[0]), 64'd0);

    // Pending branch held through the wait, applied on release
    req = 1; taken = 1;
    @(negedge clk);
    check("pend_br_frozen", 64'(fl_ifid[0]), 64'd0);
    tick(); ack = 1;
    @(negedge clk);
    check("pend_br_flush", 64'(fl_ifid[0]), 64'd1);
    check("pend_br_pc_en", 64'(pc_en[0]), 64'd1);
    tick(); idle_in();
    @(negedge clk);
    check("pend_br_flush_cnt", 64'(flush1), 64'd1);

    // Pending load-use applied on release
    req = 1; set_ld_use();
    tick(); ack = 1;
    @(negedge clk);
    check("pend_raw_pc_en", 64'(pc_en[0]), 64'd0);
    check("pend_raw_flush_idex", 64'(fl_idex[0]), 64'd1);
    check("pend_raw_en_exmem", 64'(en_exmem[0]), 64'd1);
    tick(); idle_in();

    // Zero-wait access never freezes
    req = 1; ack = 1;
    @(negedge clk);
    check("zw_pc_en", 64'(pc_en[0]), 64'd1);
    tick(); idle_in();
    @(negedge clk);
    check("zw_after", 64'(pc_en[0]), 64'd1);

    // Timeout: HALT after four wait cycles, only reset leaves it
    do_reset(); req = 1; ack = 0;
    repeat (5) tick();
    @(negedge clk);
    check("to_halted", 64'(halted[0]), 64'd1);
    check("to_mem_err", 64'(mem_err[0]), 64'd1);
    check("to_pc_en", 64'(pc_en[0]), 64'd0);
    ack = 1;
    repeat (3) tick();
    @(negedge clk);
    check("to_still_halted", 64'(halted[0]), 64'd1);
    check("to_stall_cnt", 64'(stall1), 64'd8);
    check("to_stall_sat", 64'(stall0), 64'd7);
    tick(); rstn = 0; idle_in();
    @(negedge clk);
    check("to_rst_halted", 64'(halted[0]), 64'd0);
    check("to_rst_flush_ifid", 64'(fl_ifid[0]), 64'd1);
    check("to_rst_en_memwb", 64'(en_memwb[0]), 64'd0);
    tick(); rstn = 1;
    @(negedge clk);
    check("to_post_halted", 64'(halted[0]), 64'd0);
    check("to_post_mem_err", 64'(mem_err[0]), 64'd0);
    check("to_post_stall1", 64'(stall1), 64'd0);
    check("to_post_stall0", 64'(stall0), 64'd0);
    check("to_post_pc_en", 64'(pc_en[0]), 64'd1);

    // FORWARDING=0: MEM match stalls once, EX match stalls twice
    tick(); rd_mem = 7; rw_mem = 1; rs2 = 7; u2 = 1;
    @(negedge clk);
    check("nf_mem_f0", 64'(pc_en[1]), 64'd0);
    check("nf_mem_f1", 64'(pc_en[0]), 64'd1);
    tick(); idle_in();
    @(negedge clk);
    check("nf_mem_done", 64'(pc_en[1]), 64'd1);
    tick(); rw_ex = 1; m2r = 2'b00; rd_ex = 9; rs1 = 9; u1 = 1;
    @(negedge clk);
    check("nf_ex1_f0", 64'(pc_en[1]), 64'd0);
    check("nf_ex1_f1", 64'(pc_en[0]), 64'd1);
    tick(); rw_ex = 0; rd_ex = 0; rd_mem = 9; rw_mem = 1;
    @(negedge clk);
    check("nf_ex2_f0", 64'(pc_en[1]), 64'd0);
    tick(); idle_in();
    @(negedge clk);
    check("nf_done_f0", 64'(pc_en[1]), 64'd1);
    check("nf_stall0", 64'(stall0), 64'd3);
    check("nf_stall1", 64'(stall1), 64'd0);

    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pcpu pipeline.
- Drives the enable and flush of PC, IF/ID, ID/EX, EX/MEM and MEM/WB from three event sources: load-use hazards, taken branches or jumps in EX, and a multi-cycle data-memory handshake.
- Tracks memory-wait timeout in a small FSM and keeps saturating stall and flush counters for debug.

Parameters:
FORWARDING, 1, 1: only load-use against EX stalls; 0: any RAW hazard against EX or MEM stalls
MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before entering HALT; 0 disables the timeout
CNT_W, 32, width of the performance counters

Ports:
clk_HZD  in  1  clock
rstn_HZD  in  1  synchronous active-low reset
Rs1_addr_ID  in  5  rs1 of the instruction in ID
Rs2_addr_ID  in  5  rs2 of the instruction in ID
use_rs1_ID  in  1  ID instruction reads rs1
use_rs2_ID  in  1  ID instruction reads rs2
Rd_addr_EX  in  5  rd held in ID/EX
RegWrite_EX  in  1  RegWrite held in ID/EX
MemtoReg_EX  in  2  MemtoReg held in ID/EX (MEM2REG_LOAD means a load)
Rd_addr_MEM  in  5  rd held in EX/MEM
RegWrite_MEM  in  1  RegWrite held in EX/MEM
taken_EX  in  1  branch or jump resolved taken in EX this cycle
dmem_req_MEM  in  1  MEM stage has a valid load or store
dmem_ack_MEM  in  1  data memory completes the access this cycle
PC_en  out  1  PC update enable
en_IFID  out  1  IF/ID enable
flush_IFID  out  1  IF/ID loads a NOP
en_IDEX  out  1  ID/EX enable
flush_IDEX  out  1  ID/EX loads zeroed control fields (bubble)
en_EXMEM  out  1  EX/MEM enable
en_MEMWB  out  1  MEM/WB enable
halted  out  1  FSM is in HALT
mem_err  out  1  sticky flag: memory timeout occurred
stall_cnt  out  CNT_W  cycles with PC_en=0, saturating
flush_cnt  out  CNT_W  number of taken-branch flushes, saturating

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT.
- Sampled reset (rstn_HZD=0 at a clock edge):
  - next state RUN, wait counter 0, mem_err 0, stall_cnt 0, flush_cnt 0.
  - While rstn_HZD is low, the outputs are forced to: all enables 0, flush_IFID=1, flush_IDEX=1, halted=0.
  - Reset mid-MEM_WAIT or in HALT returns to RUN on the next edge.
- Control outputs are combinational from the current state and inputs. State, counters and mem_err are registered.
- Hazard terms (x0 never counts as a hazard):
  - ld_use = RegWrite_EX & MemtoReg_EX==MEM2REG_LOAD & Rd_addr_EX!=0 & ((use_rs1_ID & Rs1_addr_ID==Rd_addr_EX) | (use_rs2_ID & Rs2_addr_ID==Rd_addr_EX)).
  - FORWARDING=0: raw = the same match against EX without the load qualifier, OR-ed with the same match against MEM/RegWrite_MEM.
  - FORWARDING=1: raw = ld_use.
- mem_stall = dmem_req_MEM & ~dmem_ack_MEM.
- Priority order: HALT > mem_stall/MEM_WAIT > taken_EX > raw > normal.
- HALT: all enables 0, flushes 0. Exit only by reset.
- Memory freeze (RUN with mem_stall, or MEM_WAIT with ack still low):
  - All enables 0, flushes 0.
  - taken_EX and raw are ignored; they stay visible and are acted on after release.
- MEM_WAIT exit:
  - With dmem_ack_MEM=1, all enables are 1 that cycle and the state returns to RUN. Zero-wait acks never leave RUN.
  - Any pending taken_EX or raw is applied in that same release cycle, using the normal priority.
- Taken branch (taken_EX=1, no freeze):
  - All enables 1, flush_IFID=1, flush_IDEX=1.
  - PC loads the target through the existing mux; this block does not handle the target.
  - flush_cnt increments.
  - A coincident raw stall is discarded because the ID instruction is squashed.
- RAW stall (no freeze, no branch): PC_en=0, en_IFID=0, en_IDEX=1 with flush_IDEX=1, en_EXMEM=1, en_MEMWB=1.
- Normal: all enables 1, flushes 0.
- Transitions:
  - RUN→MEM_WAIT on mem_stall, wait counter cleared to 1.
  - MEM_WAIT: the counter increments each cycle ack stays low.
  - MEM_WAIT→HALT when the counter reaches MEM_TIMEOUT with ack low (MEM_TIMEOUT≠0). mem_err is set on that edge.
  - MEM_WAIT→RUN on ack.
- stall_cnt increments on every cycle with PC_en=0 outside reset, including HALT. Both counters saturate at all-ones.

Decomposition:
- Package pcpu gets:
  - typedef enum logic[1:0] hzd_state_t {HZD_RUN, HZD_MEM_WAIT, HZD_HALT}
  - localparam MEM2REG_LOAD = 2'b01
  - struct pipe_ctrl_t bundling the seven enable/flush outputs
- Sub-module pipe_hazard_detect: purely combinational raw/ld_use generation, parameterised by FORWARDING.

Test Plan:
- Load-use: lw x5 in EX (RegWrite_EX=1, MemtoReg_EX=01, Rd_addr_EX=5); ID has Rs1_addr_ID=5, use_rs1_ID=1 → exactly 1 cycle with PC_en=0, en_IFID=0, flush_IDEX=1; stall_cnt=1.
- x0 / unused operand: Rd_addr_EX=0 load matching Rs1_addr_ID=0, then Rd_addr_EX=5 with Rs2_addr_ID=5 and use_rs2_ID=0 → no stall in either case.
- Branch + load-use: taken_EX=1 in the same cycle as ld_use → flush_IFID=1, flush_IDEX=1, PC_en=1; flush_cnt=1, stall_cnt=0.
- Memory wait: dmem_req_MEM=1, ack low for 3 cycles, then high → 3 cycles all enables 0 (state MEM_WAIT), 4th cycle all enables 1, state RUN; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, ack never rises → HALT after 4 wait cycles; halted=1, mem_err=1, enables 0; rstn_HZD low for 1 edge → RUN, counters 0, mem_err 0.
- FORWARDING=0: add with Rd_addr_MEM=7, RegWrite_MEM=1, Rs2_addr_ID=7, use_rs2_ID=1 → 1-cycle stall; an EX-stage match gives 2 consecutive stall cycles as the producer advances.
